// File: rtl/lsu_mem_port.sv
// Load/store initiator for a word-organised data memory with combinational read.
// Sub-word stores are done as a read-modify-write through the MERGE state.
module lsu_mem_port #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_resp_valid,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_err,
    output logic [31:0] o_mem_a,
    output logic        o_mem_we,
    output logic [31:0] o_mem_wd,
    input  logic [31:0] i_mem_rd
);

    localparam logic [0:0]  S_IDLE     = 1'b0;
    localparam logic [0:0]  S_MERGE    = 1'b1;
    localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;

    logic [0:0]  r_state;
    logic [31:0] r_addr;
    logic        r_half;
    logic [15:0] r_wdata;
    logic [31:0] r_old;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_err;

    logic        w_is_half;
    logic        w_is_word;
    logic        w_misaligned;
    logic        w_oor;
    logic        w_illegal;
    logic        w_err;
    logic        w_accept;
    logic        w_sw;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_is_half    = (i_req_funct3[1:0] == 2'b01);
    assign w_is_word    = (i_req_funct3 == 3'b010);
    assign w_misaligned = (w_is_half & i_req_addr[0]) | (w_is_word & (i_req_addr[1:0] != 2'b00));
    assign w_oor        = ({1'b0, i_req_addr} >= ADDR_LIMIT);
    // Loads reject 011/110/111; stores accept only 000/001/010.
    assign w_illegal    = i_req_we ? (i_req_funct3[2] | (i_req_funct3[1:0] == 2'b11))
                                   : ((i_req_funct3[1:0] == 2'b11) | (i_req_funct3 == 3'b110));
    assign w_err        = w_misaligned | w_oor | w_illegal;
    assign w_accept     = i_rst & (r_state == S_IDLE) & i_req_valid;
    assign w_sw         = i_req_we & w_is_word;

    assign w_byte = i_mem_rd[{i_req_addr[1:0], 3'b000} +: 8];
    assign w_half = i_req_addr[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];

    always_comb begin
        w_load = i_mem_rd;
        case (i_req_funct3)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b100:  w_load = {24'h0, w_byte};
            3'b101:  w_load = {16'h0, w_half};
            default: w_load = i_mem_rd;
        endcase
    end

    always_comb begin
        w_merged = r_old;
        if (r_half) begin
            w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata;
        end else begin
            w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
        end
    end

    always_comb begin
        o_mem_a  = {2'b00, i_req_addr[31:2]};
        o_mem_we = 1'b0;
        o_mem_wd = i_req_wdata;
        if (r_state == S_MERGE) begin
            o_mem_a  = {2'b00, r_addr[31:2]};
            o_mem_we = i_rst;
            o_mem_wd = w_merged;
        end else if (w_accept & w_sw & ~w_err) begin
            o_mem_we = 1'b1;
        end
    end

    assign o_req_ready  = i_rst & (r_state == S_IDLE);
    assign o_resp_valid = r_resp_valid;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state      <= S_IDLE;
            r_addr       <= 32'h0;
            r_half       <= 1'b0;
            r_wdata      <= 16'h0;
            r_old        <= 32'h0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_err   <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= i_req_addr;
                        r_half  <= i_req_funct3[0];
                        r_wdata <= i_req_wdata[15:0];
                        if (w_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'h0;
                            r_resp_err   <= 1'b1;
                        end else if (!i_req_we) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_load;
                            r_resp_err   <= 1'b0;
                        end else if (w_sw) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= 32'h0;
                            r_resp_err   <= 1'b0;
                        end else begin
                            r_old   <= i_mem_rd;
                            r_state <= S_MERGE;
                        end
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= 32'h0;
                    r_resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Bench for lsu_mem_port: directed scenarios plus randomized requests checked
// against a byte-lane arithmetic model of the memory.
module tb_lsu_mem_port;

    localparam int unsigned DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_a;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    int total;
    int bad;

    logic [31:0] mem [DEPTH];
    bit          written [DEPTH];
    logic [31:0] ref_mem [DEPTH];

    lsu_mem_port #(.DEPTH_WORDS(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req_valid  (req_valid),
        .o_req_ready  (req_ready),
        .i_req_we     (req_we),
        .i_req_funct3 (req_funct3),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .o_resp_valid (resp_valid),
        .o_resp_rdata (resp_rdata),
        .o_resp_err   (resp_err),
        .o_mem_a      (mem_a),
        .o_mem_we     (mem_we),
        .o_mem_wd     (mem_wd),
        .i_mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int unsigned i);
        if (i == 7) return 32'h80017F20;
        return (i * 32'h9E3779B9) ^ 32'h5A5AC3C3;
    endfunction

    function automatic logic [31:0] mem_word(input int unsigned i);
        return written[i] ? mem[i] : init_word(i);
    endfunction

    always_comb begin
        mem_rd = 32'h0;
        if (mem_a < DEPTH) begin
            mem_rd = written[mem_a[9:0]] ? mem[mem_a[9:0]] : init_word(32'(mem_a[9:0]));
        end
    end

    always @(posedge clk) begin
        if (mem_we && mem_a < DEPTH) begin
            mem[mem_a[9:0]]     <= mem_wd;
            written[mem_a[9:0]] <= 1'b1;
        end
    end

    // Reference: response and memory effect derived from width, alignment and lane arithmetic.
    function automatic void predict(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                    input logic [31:0] wd, output logic err,
                                    output logic [31:0] rdata, output int lat);
        int unsigned size, w, sh;
        logic [31:0] mask, v;
        logic legal;
        size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        err   = !legal || (addr % size != 0) || (longint'(addr) >= 4 * longint'(DEPTH));
        mask  = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        rdata = 32'h0;
        lat   = 1;
        w     = addr >> 2;
        sh    = 8 * (addr % 4);
        if (!err) begin
            if (!we) begin
                v = (ref_mem[w] >> sh) & mask;
                if (f3 < 3'd4 && size < 4 && v[8 * size - 1]) v = v | ~mask;
                rdata = v;
            end else if (size == 4) begin
                ref_mem[w] = wd;
            end else begin
                ref_mem[w] = (ref_mem[w] & ~(mask << sh)) | ((wd & mask) << sh);
                lat = 2;
            end
        end
    endfunction

    // Drives one request and records what the DUT did; starts and ends just after a posedge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, output int lat, output logic err,
                         output logic [31:0] rdata, output int nwr, output logic [31:0] last_wd,
                         output int busy);
        int n;
        lat = -1; err = 1'bx; rdata = 'x; nwr = 0; last_wd = 32'h0; busy = 0;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (mem_we) begin nwr++; last_wd = mem_wd; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (mem_we) begin nwr++; last_wd = mem_wd; end
            if (!req_ready) busy++;
            if (resp_valid) begin
                lat = k; err = resp_err; rdata = resp_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h1C; req_wdata = 32'h1111_1111;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (mem_we !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: we=%b rv=%b rdy=%b, want 0 0 0",
                         c, mem_we, resp_valid, req_ready);
            end
        end
        @(posedge clk);
        #1 rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
        begin
            bad++;
            $display("FAIL reset_release: rdy=%b rv=%b rd=%h err=%b, want 1 0 0 0",
                     req_ready, resp_valid, resp_rdata, resp_err);
        end
        total++;
        if (mem_word(7) !== 32'h80017F20) begin
            bad++;
            $display("FAIL reset_mem: word7=%h, want 80017f20", mem_word(7));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_loads();
        logic [31:0] addrs [5] = '{32'h1C, 32'h1D, 32'h1F, 32'h1E, 32'h1E};
        logic [2:0]  f3s   [5] = '{3'b010, 3'b000, 3'b000, 3'b101, 3'b001};
        logic [31:0] exps  [5] = '{32'h80017F20, 32'h0000007F, 32'hFFFFFF80, 32'h00008001,
                                   32'hFFFF8001};
        int lat, nwr, busy, mlat;
        logic err, merr;
        logic [31:0] rd, lwd, mrd;
        for (int i = 0; i < 5; i++) begin
            predict(1'b0, f3s[i], addrs[i], 32'h0, merr, mrd, mlat);
            issue(1'b0, f3s[i], addrs[i], 32'h0, lat, err, rd, nwr, lwd, busy);
            total++;
            if (rd !== exps[i] || err !== 1'b0 || lat != 1) begin
                bad++;
                $display("FAIL load_%0d: rdata=%h err=%b lat=%0d, want %h 0 1",
                         i, rd, err, lat, exps[i]);
            end
        end
    endtask

    task automatic test_subword();
        int lat, nwr, busy, mlat;
        logic err, merr;
        logic [31:0] rd, lwd, mrd;
        predict(1'b1, 3'b000, 32'h1D, 32'hAB, merr, mrd, mlat);
        issue(1'b1, 3'b000, 32'h1D, 32'hAB, lat, err, rd, nwr, lwd, busy);
        total++;
        if (lat != 2 || busy != 1 || nwr != 1 || lwd !== 32'h8001AB20 || err !== 1'b0) begin
            bad++;
            $display("FAIL sb: lat=%0d busy=%0d nwr=%0d wd=%h err=%b, want 2 1 1 8001ab20 0",
                     lat, busy, nwr, lwd, err);
        end
        predict(1'b1, 3'b001, 32'h1E, 32'h1234, merr, mrd, mlat);
        issue(1'b1, 3'b001, 32'h1E, 32'h1234, lat, err, rd, nwr, lwd, busy);
        total++;
        if (lat != 2 || busy != 1 || err !== 1'b0) begin
            bad++;
            $display("FAIL sh: lat=%0d busy=%0d err=%b, want 2 1 0", lat, busy, err);
        end
        predict(1'b0, 3'b010, 32'h1C, 32'h0, merr, mrd, mlat);
        issue(1'b0, 3'b010, 32'h1C, 32'h0, lat, err, rd, nwr, lwd, busy);
        total++;
        if (rd !== 32'h1234AB20 || lat != 1) begin
            bad++;
            $display("FAIL sh_readback: rdata=%h lat=%0d, want 1234ab20 1", rd, lat);
        end
    endtask

    task automatic test_back_to_back();
        int mlat;
        logic merr;
        logic [31:0] mrd;
        predict(1'b1, 3'b010, 32'h20, 32'hDEADBEEF, merr, mrd, mlat);
        predict(1'b0, 3'b010, 32'h20, 32'h0, merr, mrd, mlat);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h20; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 32'h0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_sw: rv=%b err=%b rdy=%b, want 1 0 1", resp_valid, resp_err, req_ready);
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (resp_valid !== 1'b1 || resp_rdata !== mrd || resp_err !== 1'b0) begin
            bad++;
            $display("FAIL b2b_lw: rv=%b rdata=%h err=%b, want 1 %h 0",
                     resp_valid, resp_rdata, resp_err, mrd);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_errors();
        logic        wes   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3s   [4] = '{3'b010, 3'b001, 3'b010, 3'b100};
        logic [31:0] addrs [4] = '{32'h1E, 32'h1F, 32'h1000, 32'h1C};
        int lat, nwr, busy, mlat;
        logic err, merr;
        logic [31:0] rd, lwd, mrd;
        for (int i = 0; i < 4; i++) begin
            predict(wes[i], f3s[i], addrs[i], 32'hCAFEF00D, merr, mrd, mlat);
            issue(wes[i], f3s[i], addrs[i], 32'hCAFEF00D, lat, err, rd, nwr, lwd, busy);
            total++;
            if (err !== 1'b1 || rd !== 32'h0 || lat != 1 || nwr != 0) begin
                bad++;
                $display("FAIL err_%0d: err=%b rdata=%h lat=%0d nwr=%0d, want 1 0 1 0",
                         i, err, rd, lat, nwr);
            end
            total++;
            if (mem_word(7) !== ref_mem[7]) begin
                bad++;
                $display("FAIL err_mem_%0d: word7=%h, want %h", i, mem_word(7), ref_mem[7]);
            end
        end
    endtask

    task automatic test_merge_reset();
        int n;
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h1C; req_wdata = 32'h55;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0; rst = 1'b0;
        @(negedge clk);
        total++;
        if (mem_we !== 1'b0 || resp_valid !== 1'b0) begin
            bad++;
            $display("FAIL merge_abort: we=%b rv=%b, want 0 0", mem_we, resp_valid);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                bad++;
                $display("FAIL merge_after_%0d: rv=%b rdy=%b, want 0 1", c, resp_valid, req_ready);
            end
        end
        total++;
        if (mem_word(7) !== ref_mem[7]) begin
            bad++;
            $display("FAIL merge_mem: word7=%h, want %h", mem_word(7), ref_mem[7]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        int lat, nwr, busy, mlat, sel;
        logic err, merr, we;
        logic [2:0] f3;
        logic [31:0] rd, lwd, mrd, addr, wd;
        int unsigned w;
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 15);
            if (sel == 0) addr = 4 * DEPTH + $urandom_range(0, 64);
            else if (sel == 1) addr = $urandom;
            else addr = $urandom_range(0, 63);
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            wd = $urandom;
            predict(we, f3, addr, wd, merr, mrd, mlat);
            issue(we, f3, addr, wd, lat, err, rd, nwr, lwd, busy);
            total++;
            if (err !== merr || rd !== mrd || lat != mlat) begin
                bad++;
                $display("FAIL rand_%0d we=%b f3=%0d a=%h: err=%b rd=%h lat=%0d, want %b %h %0d",
                         i, we, f3, addr, err, rd, lat, merr, mrd, mlat);
            end
            total++;
            if (nwr != ((we && !merr) ? 1 : 0) || busy != mlat - 1) begin
                bad++;
                $display("FAIL rand_wr_%0d: nwr=%0d busy=%0d, want %0d %0d",
                         i, nwr, busy, (we && !merr) ? 1 : 0, mlat - 1);
            end
            w = addr >> 2;
            if (w < DEPTH) begin
                total++;
                if (mem_word(w) !== ref_mem[w]) begin
                    bad++;
                    $display("FAIL rand_mem_%0d: word%0d=%h, want %h", i, w, mem_word(w), ref_mem[w]);
                end
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_word(i);
        test_reset();
        test_loads();
        test_subword();
        test_back_to_back();
        test_errors();
        test_merge_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
# lsu_mem_port

Load/store initiator for the word-organised data memory: accepts one load or store request per handshake from the MEM stage and drives the memory's address, write-enable and write-data ports. It returns sign- or zero-extended load data and flags misaligned, out-of-range or illegal accesses. The memory only writes whole words, so byte and halfword stores use a two-cycle read-modify-write sequence. The block sits between the pipeline MEM stage and the data memory; the memory read is combinational and its write takes effect at the clock edge.

## Interface
- DEPTH_WORDS, 1024: memory depth in 32-bit words. Byte addresses at or above 4*DEPTH_WORDS are out of range.
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request. Equals rst & (state==IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle pulse; the request has completed.
- resp_rdata  out  32  extended load data. 0 for stores and errors.
- resp_err  out  1  valid with resp_valid. Access was rejected and memory is untouched.
- mem_a  out  32  word index, {2'b0, addr[31:2]}.
- mem_we  out  1  memory write enable.
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data (combinational from mem_a).

## Operation
- **States:** IDLE and MERGE.
- **Accept condition:** a request is accepted in IDLE when req_valid is high and rst is high. On acceptance, addr, funct3, we and wdata are latched.
- **Error check** (evaluated at acceptance):
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, is misaligned.
  - Any address ≥ 4*DEPTH_WORDS is out of range.
  - Load funct3 ∈ {011,110,111} is illegal.
  - Store funct3 ∉ {000,001,010} is illegal.
  - On error: no memory write, no state change. resp_err=1 and resp_rdata=0 on the next cycle.
- **Load:**
  - mem_a is driven from req_addr in the accept cycle.
  - The lane is selected from mem_rd by addr[1:0] (byte) or addr[1] (halfword).
  - The result is sign-extended for B/H and zero-extended for BU/HU, then registered into resp_rdata.
- **SW:** mem_we=1 and mem_wd=req_wdata in the accept cycle, combinationally. State stays IDLE.
- **SB/SH, accept cycle:** mem_rd is captured into an old-word register and the state goes to MERGE. No write occurs in this cycle.
- **SB/SH, MERGE cycle:**
  - mem_a is driven from the latched address and mem_we=1.
  - mem_wd is the old word with the selected lane replaced by wdata[7:0] or wdata[15:0]. Other lanes are unchanged.
  - The next state is IDLE.
- **In IDLE with no accept:** mem_we=0 and mem_a = req_addr word index.
- **Reset:**
  - While rst=0: mem_we=0 and req_ready=0, forced combinationally.
  - At a clock edge with rst=0: state←IDLE, resp_valid←0, resp_rdata←0, resp_err←0, old-word register←0.
  - Reset asserted during MERGE aborts the write. No response is produced for the aborted request.

## Timing
- **Latency (accept cycle = cycle 0):**
  - Load, SW and error: resp_valid at cycle 1.
  - SB/SH: resp_valid at cycle 2.
  - The SW write and the SB/SH merge write commit at the end of cycle 0 and cycle 1 respectively.
- **Throughput:** one request per cycle for loads, SW and errors. SB/SH hold req_ready low for exactly one cycle (MERGE).
- **Response pulse:** resp_valid is high for one cycle per accepted request. resp_rdata and resp_err are valid only while resp_valid is high and hold their value otherwise.
- **Read-after-store:** a load accepted the cycle after SW, or the cycle after MERGE, to the same word returns the new data.
- **Ignored requests:** req_valid while req_ready=0 is ignored. The requester holds the request until accepted.

## Test plan
- **Reset:** hold rst=0 for 3 cycles with req_valid=1 and req_we=1 → mem_we stays 0, resp_valid stays 0, memory unchanged. After release, req_ready=1.
- **Loads** (word 7 preloaded 0x80017F20):
  - LW 0x1C → resp_rdata 0x80017F20 at cycle 1.
  - LB 0x1D → 0x0000007F.
  - LB 0x1F → 0xFFFFFF80.
  - LHU 0x1E → 0x00008001.
  - LH 0x1E → 0xFFFF8001.
- **SB/SH:**
  - SB 0x1D with wdata 0xAB → req_ready low for 1 cycle, mem_wd=0x8001AB20 in MERGE, resp_valid at cycle 2.
  - Then SH 0x1E with wdata 0x1234, followed by LW 0x1C → 0x1234AB20.
- **Back-to-back:** SW 0x20 (0xDEADBEEF) then LW 0x20 on consecutive cycles → two resp pulses on consecutive cycles, load returns 0xDEADBEEF.
- **Errors:**
  - LW 0x1E → resp_err=1 and rdata=0.
  - SH 0x1F → resp_err=1.
  - LW 0x1000 → resp_err=1 (out of range).
  - Store with funct3 100 → resp_err=1.
  - Memory is unchanged in all cases and resp arrives at cycle 1.
- **Reset during MERGE:** SB 0x1C with 0x55, then rst=0 in the MERGE cycle → word 7 unchanged, no resp_valid, state IDLE after release.
